// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_e      : divider FSM state encoding
//   DivOpSignedBit   : div_op bit selecting signed DIV
//   DivOpUnsignedBit : div_op bit selecting unsigned DIVU
//   DivResultWd      : width of {remainder, quotient} at the default operand width
package seq_divider_pkg;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivBusy = 2'd1,
        DivDone = 2'd2
    } div_state_e;

    localparam int unsigned DivOpSignedBit   = 0;
    localparam int unsigned DivOpUnsignedBit = 1;
    localparam int unsigned DivResultWd      = 64;

    typedef logic [DivResultWd-1:0] div_result_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division step (combinational).
//   rem_in   : current partial remainder (WIDTH+1 bits)
//   next_bit : next dividend bit shifted into the remainder
//   divisor  : magnitude of the divisor
//   rem_out  : partial remainder after the trial subtraction
//   q_bit    : quotient bit, set when the subtraction did not borrow
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, next_bit};
        diff    = shifted - {2'b00, divisor};
        // The top bit of diff is the borrow out of the trial subtraction.
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
//   clk, reset      : clock and asynchronous active-high reset
//   cancel          : flush, aborts any operation and returns to idle
//   div_op          : [0] signed, [1] unsigned, 2'b00 no request
//   dividend/divisor: operands, sampled only on the acceptance edge
//   div_in_valid    : request valid; div_in_ready high only when idle
//   div_result      : {remainder, quotient}, meaningful while div_out_valid
//   div_out_valid   : result valid; div_out_ready accepts it
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cancel,
    input  logic [1:0]         div_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               div_in_valid,
    output logic               div_in_ready,
    output logic [2*WIDTH-1:0] div_result,
    output logic               div_out_valid,
    input  logic               div_out_ready
);

    div_state_e       state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH:0]   rem_q;
    // Holds the dividend magnitude; quotient bits shift in as dividend bits shift out.
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] dividend_orig_q;
    logic             is_signed_q;
    logic             sign_q;
    logic             sign_r;
    logic             div_by_zero_q;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic             request;
    logic             op_signed;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // Signed wins when both op bits are set.
    assign op_signed = div_op[DivOpSignedBit];
    assign request   = div_in_valid && (div_op[DivOpSignedBit] || div_op[DivOpUnsignedBit]);

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .next_bit(quo_q[WIDTH-1]),
        .divisor (divisor_q),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= DivIdle;
            counter         <= '0;
            rem_q           <= '0;
            quo_q           <= '0;
            divisor_q       <= '0;
            dividend_orig_q <= '0;
            is_signed_q     <= 1'b0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            div_by_zero_q   <= 1'b0;
            div_in_ready    <= 1'b1;
            div_out_valid   <= 1'b0;
        end else if (cancel) begin
            state         <= DivIdle;
            counter       <= '0;
            div_in_ready  <= 1'b1;
            div_out_valid <= 1'b0;
        end else begin
            unique case (state)
                DivIdle: begin
                    if (request) begin
                        state           <= DivBusy;
                        div_in_ready    <= 1'b0;
                        counter         <= '0;
                        rem_q           <= '0;
                        is_signed_q     <= op_signed;
                        sign_q          <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r          <= dividend[WIDTH-1];
                        quo_q           <= (op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                        divisor_q       <= (op_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                        div_by_zero_q   <= (divisor == '0);
                        dividend_orig_q <= dividend;
                    end
                end
                DivBusy: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        state         <= DivDone;
                        counter       <= '0;
                        div_out_valid <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DivDone: begin
                    if (div_out_ready) begin
                        state         <= DivIdle;
                        div_out_valid <= 1'b0;
                        div_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= DivIdle;
                    div_in_ready  <= 1'b1;
                    div_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sign fix-up: quotient sign is the XOR of operand signs, remainder follows the dividend.
    always_comb begin
        quotient  = quo_q;
        remainder = rem_q[WIDTH-1:0];
        if (is_signed_q && sign_q) begin
            quotient = -quo_q;
        end
        if (is_signed_q && sign_r) begin
            remainder = -rem_q[WIDTH-1:0];
        end
        div_result = '0;
        if (state == DivDone) begin
            div_result = div_by_zero_q ? {dividend_orig_q, {WIDTH{1'b1}}} : {remainder, quotient};
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized traffic,
// all checked against a cycle-count model of the divide handshake.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_in_valid = 1'b0;
    logic        div_in_ready;
    logic [63:0] div_result;
    logic        div_out_valid;
    logic        div_out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cancel       (cancel),
        .div_op       (div_op),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_in_valid (div_in_valid),
        .div_in_ready (div_in_ready),
        .div_result   (div_result),
        .div_out_valid(div_out_valid),
        .div_out_ready(div_out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: 64-bit host arithmetic, truncating division.
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Handshake model: a job is accepted when idle, its result appears 32 cycles later
    // and stays until consumed; cancel or reset drops everything.
    bit          m_have_job;
    int          m_age;
    logic [63:0] m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_have_job <= 1'b0;
            m_age      <= 0;
            m_res      <= '0;
        end else if (cancel) begin
            m_have_job <= 1'b0;
        end else if (!m_have_job) begin
            if (div_in_valid && (div_op != 2'b00)) begin
                m_have_job <= 1'b1;
                m_age      <= 0;
                m_res      <= ref_div(div_op, dividend, divisor);
            end
        end else if (m_age < 32) begin
            m_age <= m_age + 1;
        end else if (div_out_ready) begin
            m_have_job <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model_ready", div_in_ready, !m_have_job);
            check("model_valid", div_out_valid, m_have_job && (m_age >= 32));
            if (m_have_job && (m_age >= 32)) check("model_result", div_result, m_res);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Waits for div_out_valid after an acceptance edge; returns cycle count (41 on timeout).
    task automatic wait_valid(output int n);
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n <= 40) begin
            @(posedge clk);
            n++;
            #1;
            if (div_out_valid) seen = 1;
        end
    endtask

    // Issues one request at posedge+2 and checks latency and result; returns at posedge+2.
    task automatic do_div(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int n;
        div_op = op;
        dividend = a;
        divisor = b;
        div_in_valid = 1'b1;
        div_out_ready = 1'b1;
        @(posedge clk);
        #2;
        div_in_valid = 1'b0;
        div_op = 2'b00;
        dividend = $urandom;
        divisor = $urandom;
        wait_valid(n);
        check({name, "_latency"}, 64'(n), 64'd32);
        check({name, "_result"}, div_result, exp);
        @(posedge clk);
        #1;
        check({name, "_idle"}, {62'h0, div_in_ready, div_out_valid}, 64'b10);
        #1;
    endtask

    task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_op = op;
        dividend = a;
        divisor = b;
        div_in_valid = 1'b1;
        @(posedge clk);
        #2;
        div_in_valid = 1'b0;
        div_op = 2'b00;
    endtask

    initial begin
        int n;
        int highs;
        logic [63:0] held;

        #3 reset = 1'b1;
        #1;
        check("reset_ready", 64'(div_in_ready), 64'd1);
        check("reset_valid", 64'(div_out_valid), 64'd0);
        check("reset_result", div_result, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        do_div("udiv_7_2", 2'b10, 32'd7, 32'd2, {32'd1, 32'd3});
        do_div("sdiv_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("sdiv_7_m2", 2'b01, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
        do_div("both_bits_signed", 2'b11, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("sdiv_zero", 2'b01, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF});
        do_div("udiv_zero", 2'b10, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF});
        do_div("sdiv_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        do_div("udiv_big", 2'b10, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF});

        // Backpressure in DONE, then back-to-back request.
        div_out_ready = 1'b0;
        start_req(2'b10, 32'd50, 32'd5);
        wait_valid(n);
        check("bp_latency", 64'(n), 64'd32);
        held = div_result;
        check("bp_result", held, {32'd0, 32'd10});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid_hold", 64'(div_out_valid), 64'd1);
            check("bp_result_hold", div_result, held);
        end
        #1 div_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {62'h0, div_in_ready, div_out_valid}, 64'b10);
        #1;
        do_div("b2b_100_7", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14});

        // Cancel sampled on the 15th iteration edge.
        start_req(2'b10, 32'd1000, 32'd10);
        repeat (14) @(posedge clk);
        #2 cancel = 1'b1;
        @(posedge clk);
        #1;
        check("cancel_idle", {62'h0, div_in_ready, div_out_valid}, 64'b10);
        #1 cancel = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (div_out_valid) highs++;
        end
        check("cancel_no_valid", 64'(highs), 64'd0);
        #1;
        do_div("after_cancel_9_3", 2'b10, 32'd9, 32'd3, {32'd0, 32'd3});

        // Asynchronous reset between edges, mid-BUSY and in DONE.
        start_req(2'b01, 32'd1000, 32'd10);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("areset_busy_ready", 64'(div_in_ready), 64'd1);
        check("areset_busy_valid", 64'(div_out_valid), 64'd0);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 div_out_ready = 1'b0;
        start_req(2'b10, 32'd50, 32'd5);
        wait_valid(n);
        check("pre_reset_valid", 64'(div_out_valid), 64'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("areset_done_valid", 64'(div_out_valid), 64'd0);
        check("areset_done_result", div_result, 64'd0);
        check("areset_done_ready", 64'(div_in_ready), 64'd1);
        #1 reset = 1'b0;
        div_out_ready = 1'b1;
        @(posedge clk);
        #2;

        // div_op = 2'b00 requests are ignored.
        div_in_valid = 1'b1;
        div_op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            dividend = $urandom;
            divisor = $urandom;
            @(posedge clk);
            #1;
            check("nop_req_state", {62'h0, div_in_ready, div_out_valid}, 64'b10);
            #1;
        end
        div_in_valid = 1'b0;

        // Randomized traffic; the model and compare process do the checking.
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #2;
            div_in_valid = ($urandom_range(0, 1) == 1);
            div_op = 2'($urandom_range(0, 3));
            dividend = pick();
            divisor = pick();
            div_out_ready = ($urandom_range(0, 9) < 6);
            cancel = ($urandom_range(0, 199) < 3);
        end
        @(posedge clk);
        #2;
        div_in_valid = 1'b0;
        cancel = 1'b0;
        div_out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("drain_idle", {62'h0, div_in_ready, div_out_valid}, 64'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
